// File: rtl/elevator_pkg.sv
// elevator_pkg: shared encodings and default parameter values for the elevator goal scheduler.
package elevator_pkg;

   // Scheduler sweep state.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } state_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Default floor labels and sizing.
   localparam int unsigned FLOOR_GROUND    = 0;
   localparam int unsigned DEF_N_FLOORS    = 3;
   localparam int unsigned DEF_FW          = 2;
   localparam int unsigned DEF_PARK_FLOOR  = FLOOR_GROUND;
   localparam int unsigned DEF_PARK_CYCLES = 16;

endpackage

// File: rtl/goal_scheduler_goal_pick.sv
// goal_pick: combinational SCAN goal selection from the remaining calls, the current floor and
// the sweep state. Returns the next goal, its valid bit and the next sweep state.
module goal_pick
   import elevator_pkg::*;
#(
   parameter int unsigned N_FLOORS = DEF_N_FLOORS,
   parameter int unsigned FW       = DEF_FW
) (
   input  logic [N_FLOORS-1:0] rem,
   input  logic [FW-1:0]       f,
   input  state_e              state,
   output logic [FW-1:0]       goal,
   output logic                goal_valid,
   output state_e              state_next,
   output logic                any_above
);

   logic          any_below;
   logic [FW-1:0] lo_above;
   logic [FW-1:0] hi_below;
   logic          take_up;

   // Closest remaining call on each side of the current floor.
   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      lo_above  = '0;
      hi_below  = '0;
      for (int unsigned i = 0; i < N_FLOORS; i++) begin
         if (rem[i] && (i > 32'(f)) && !any_above) begin
            any_above = 1'b1;
            lo_above  = FW'(i);
         end
         if (rem[i] && (i < 32'(f))) begin
            any_below = 1'b1;
            hi_below  = FW'(i);
         end
      end
   end

   // Sweep decision; differences cannot wrap because hi_below < f < lo_above when both exist.
   always_comb begin
      take_up    = (lo_above - f) <= (f - hi_below);
      goal       = lo_above;
      goal_valid = 1'b1;
      state_next = ST_UP;
      case (state)
         ST_UP: begin
            if (!any_above && any_below) begin
               goal       = hi_below;
               state_next = ST_DOWN;
            end else if (!any_above) begin
               goal_valid = 1'b0;
               state_next = ST_IDLE;
            end
         end
         ST_DOWN: begin
            if (any_below) begin
               goal       = hi_below;
               state_next = ST_DOWN;
            end else if (!any_above) begin
               goal_valid = 1'b0;
               state_next = ST_IDLE;
            end
         end
         default: begin
            // Tie on distance goes up.
            if (any_above && (!any_below || take_up)) begin
               state_next = ST_UP;
            end else if (any_below) begin
               goal       = hi_below;
               state_next = ST_DOWN;
            end else begin
               goal_valid = 1'b0;
               state_next = ST_IDLE;
            end
         end
      endcase
   end

endmodule

// File: rtl/goal_scheduler.sv
// goal_scheduler: latches floor calls, clears them on arrival and selects the next goal floor
// with a SCAN sweep. The goal is frozen while the car moves or sits between floors.
// Optional idle parking is built when GOAL_SCHEDULER_PARK_EN is defined.
module goal_scheduler
   import elevator_pkg::*;
#(
   parameter int unsigned N_FLOORS    = 3,
   parameter int unsigned FW          = 2,
   parameter int unsigned PARK_FLOOR  = 0,
   parameter int unsigned PARK_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [FW-1:0]       floor,
   input  logic [N_FLOORS-1:0] req,
   input  logic                moving,
   output logic [FW-1:0]       gf,
   output logic                gf_valid,
   output logic                dir,
   output logic [N_FLOORS-1:0] pending,
   output logic                served
);

   state_e              state_q, state_d;
   logic [FW-1:0]       gf_q, gf_d;
   logic                gf_valid_q, gf_valid_d;
   logic                dir_q, dir_d;
   logic [N_FLOORS-1:0] pending_q, pending_d;
   logic                served_q, served_d;

   logic [N_FLOORS-1:0] eff;
   logic [N_FLOORS-1:0] here;
   logic [N_FLOORS-1:0] rem;
   logic                floor_ok;
   logic                stopped;
   logic [FW-1:0]       pick_goal;
   logic                pick_valid;
   state_e              pick_state;
   logic                pick_above;
   logic                park_active;
   logic                park_go;

   assign eff      = pending_q | req;
   assign floor_ok = (32'(floor) < N_FLOORS);
   assign stopped  = !moving && floor_ok;
   assign here     = floor_ok ? (N_FLOORS'(1) << floor) : '0;
   assign rem      = eff & ~here;

   goal_pick #(
      .N_FLOORS (N_FLOORS),
      .FW       (FW)
   ) u_goal_pick (
      .rem        (rem),
      .f          (floor),
      .state      (state_q),
      .goal       (pick_goal),
      .goal_valid (pick_valid),
      .state_next (pick_state),
      .any_above  (pick_above)
   );

`ifdef GOAL_SCHEDULER_PARK_EN
   localparam int unsigned PCW = $clog2(PARK_CYCLES + 1);

   logic [PCW-1:0] park_cnt_q, park_cnt_d;
   logic           park_q, park_d;
   logic           idle_now;

   assign idle_now    = (state_q == ST_IDLE) && !moving && (eff == '0);
   assign park_active = park_q && (eff == '0);
   assign park_go     = idle_now && floor_ok && (32'(park_cnt_q) >= PARK_CYCLES - 1) &&
                        (floor != FW'(PARK_FLOOR));

   // Idle counter saturates; a parking trip is dropped as soon as a real call is seen stopped.
   always_comb begin
      park_cnt_d = '0;
      if (idle_now) begin
         park_cnt_d = (park_cnt_q == PCW'(PARK_CYCLES)) ? park_cnt_q : park_cnt_q + 1'b1;
      end
      park_d = park_q;
      if (stopped) begin
         if (!park_active || (floor == FW'(PARK_FLOOR))) begin
            park_d = 1'b0;
         end
      end
      if (park_go) begin
         park_d = 1'b1;
      end
   end

   // Parking counter and trip flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         park_cnt_q <= '0;
         park_q     <= 1'b0;
      end else begin
         park_cnt_q <= park_cnt_d;
         park_q     <= park_d;
      end
   end
`else
   logic unused_park_cycles;

   assign unused_park_cycles = ^PARK_CYCLES;
   assign park_active        = 1'b0;
   assign park_go            = 1'b0;
`endif

   // Next goal, call register and sweep state.
   always_comb begin
      state_d    = state_q;
      gf_d       = gf_q;
      gf_valid_d = gf_valid_q;
      pending_d  = eff;
      served_d   = 1'b0;
      dir_d      = dir_q;
      if (stopped) begin
         pending_d = rem;
         if (park_active) begin
            // Parking trip: hold the goal until the park floor is reached.
            if (floor == FW'(PARK_FLOOR)) begin
               state_d    = ST_IDLE;
               gf_valid_d = 1'b0;
            end
         end else if (|(eff & here)) begin
            gf_d       = floor;
            gf_valid_d = 1'b1;
            served_d   = 1'b1;
            if ((state_q == ST_IDLE) && pick_above) begin
               state_d = ST_UP;
            end
         end else begin
            gf_valid_d = pick_valid;
            state_d    = pick_state;
            if (pick_valid) begin
               gf_d = pick_goal;
            end
         end
         if (park_go) begin
            gf_d       = FW'(PARK_FLOOR);
            gf_valid_d = 1'b1;
            state_d    = (32'(floor) < PARK_FLOOR) ? ST_UP : ST_DOWN;
         end
      end
      if (state_d == ST_UP) begin
         dir_d = DIR_UP;
      end else if (state_d == ST_DOWN) begin
         dir_d = DIR_DOWN;
      end
   end

   // Registered outputs and state; reset discards all calls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gf_q       <= '0;
         gf_valid_q <= 1'b0;
         dir_q      <= DIR_DOWN;
         pending_q  <= '0;
         served_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         gf_q       <= gf_d;
         gf_valid_q <= gf_valid_d;
         dir_q      <= dir_d;
         pending_q  <= pending_d;
         served_q   <= served_d;
      end
   end

   assign gf       = gf_q;
   assign gf_valid = gf_valid_q;
   assign dir      = dir_q;
   assign pending  = pending_q;
   assign served   = served_q;

endmodule

// File: tb/tb_goal_scheduler.sv
// tb_goal_scheduler: directed scenarios plus randomized traffic against a floor-scanning
// reference model for a 4-floor scheduler, and an invalid-floor case on a 3-floor build.
module tb_goal_scheduler;

   localparam int NF = 4;
   localparam int PF = 2;
   localparam int PC = 4;
   localparam int M_IDLE = 0;
   localparam int M_UP   = 1;
   localparam int M_DOWN = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [1:0] floor;
   logic [3:0] req;
   logic       moving;
   logic [1:0] gf;
   logic       gf_valid;
   logic       dir;
   logic [3:0] pending;
   logic       served;

   logic       rst3_n;
   logic [1:0] floor3;
   logic [2:0] req3;
   logic       moving3;
   logic [1:0] gf3;
   logic       gf_valid3;
   logic       dir3;
   logic [2:0] pending3;
   logic       served3;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   logic [3:0] m_pend = '0;
   int         m_gf = 0;
   bit         m_valid = 0;
   bit         m_dir = 0;
   bit         m_served = 0;
   bit         m_park = 0;
   int         m_mode = M_IDLE;
   int         m_cnt = 0;

   logic [8:0] act;
   logic [7:0] act3;
   assign act  = {gf, gf_valid, dir, pending, served};
   assign act3 = {gf3, gf_valid3, dir3, pending3, served3};

   goal_scheduler #(
      .N_FLOORS    (4),
      .FW          (2),
      .PARK_FLOOR  (PF),
      .PARK_CYCLES (PC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .floor    (floor),
      .req      (req),
      .moving   (moving),
      .gf       (gf),
      .gf_valid (gf_valid),
      .dir      (dir),
      .pending  (pending),
      .served   (served)
   );

   goal_scheduler #(
      .N_FLOORS (3),
      .FW       (2)
   ) dut3 (
      .clk      (clk),
      .rst_n    (rst3_n),
      .floor    (floor3),
      .req      (req3),
      .moving   (moving3),
      .gf       (gf3),
      .gf_valid (gf_valid3),
      .dir      (dir3),
      .pending  (pending3),
      .served   (served3)
   );

   function automatic logic [8:0] m_vec();
      return {2'(m_gf), m_valid, m_dir, m_pend, m_served};
   endfunction

   // Nearest call strictly above / below floor f, or -1.
   function automatic int near_above(input logic [3:0] r, input int f);
      for (int d = 1; d < NF; d++) begin
         if ((f + d < NF) && r[f+d]) return f + d;
      end
      return -1;
   endfunction

   function automatic int near_below(input logic [3:0] r, input int f);
      for (int d = 1; d < NF; d++) begin
         if ((f - d >= 0) && r[f-d]) return f - d;
      end
      return -1;
   endfunction

   task automatic model_step(input logic rn, input int fl, input logic [3:0] rq, input logic mv);
      logic [3:0] eff;
      logic [3:0] rem;
      int         up;
      int         dn;
      int         old_mode;
      bit         hit;
      if (!rn) begin
         m_pend   = '0;
         m_gf     = 0;
         m_valid  = 0;
         m_dir    = 0;
         m_served = 0;
         m_mode   = M_IDLE;
         m_park   = 0;
         m_cnt    = 0;
         return;
      end
      eff      = m_pend | rq;
      old_mode = m_mode;
      m_served = 0;
      hit      = 0;
`ifdef GOAL_SCHEDULER_PARK_EN
      begin
         bit idle_c;
         idle_c = (old_mode == M_IDLE) && !mv && (eff == 4'b0);
         hit    = idle_c && (m_cnt >= PC - 1) && (fl < NF) && (fl != PF);
         if (!idle_c) m_cnt = 0;
         else if (m_cnt < PC) m_cnt++;
      end
`endif
      if (mv || fl >= NF) begin
         m_pend = eff;
      end else begin
         rem     = eff;
         rem[fl] = 1'b0;
         m_pend  = rem;
         up      = near_above(rem, fl);
         dn      = near_below(rem, fl);
         if (m_park && (eff == 4'b0)) begin
            if (fl == PF) begin
               m_mode  = M_IDLE;
               m_valid = 0;
               m_park  = 0;
            end
         end else begin
            m_park = 0;
            if (eff[fl]) begin
               m_gf     = fl;
               m_valid  = 1;
               m_served = 1;
               if (old_mode == M_IDLE && up >= 0) m_mode = M_UP;
            end else if (up < 0 && dn < 0) begin
               m_valid = 0;
               m_mode  = M_IDLE;
            end else begin
               m_valid = 1;
               if (old_mode == M_UP) begin
                  if (up >= 0) begin m_gf = up; m_mode = M_UP; end
                  else begin m_gf = dn; m_mode = M_DOWN; end
               end else if (old_mode == M_DOWN) begin
                  if (dn >= 0) begin m_gf = dn; m_mode = M_DOWN; end
                  else begin m_gf = up; m_mode = M_UP; end
               end else begin
                  if (up >= 0 && (dn < 0 || (up - fl) <= (fl - dn))) begin
                     m_gf = up; m_mode = M_UP;
                  end else begin
                     m_gf = dn; m_mode = M_DOWN;
                  end
               end
            end
         end
         if (hit) begin
            m_gf    = PF;
            m_valid = 1;
            m_mode  = (PF > fl) ? M_UP : M_DOWN;
            m_park  = 1;
         end
      end
      if (m_mode == M_UP) m_dir = 1;
      else if (m_mode == M_DOWN) m_dir = 0;
   endtask

   task automatic drive(input logic rn, input logic [1:0] fl, input logic [3:0] rq,
                        input logic mv);
      rst_n  = rn;
      floor  = fl;
      req    = rq;
      moving = mv;
      @(posedge clk);
      #1;
      model_step(rn, int'(fl), rq, mv);
   endtask

   task automatic test_invalid_floor();
      rst_n = 1'b0; floor = 2'd0; req = 4'b0; moving = 1'b0;
      rst3_n = 1'b0; floor3 = 2'd0; req3 = 3'b0; moving3 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (act3 !== 8'b0) begin
         errors++; $display("FAIL inv_reset: got %b expected %b", act3, 8'b0);
      end
      rst3_n = 1'b1; floor3 = 2'b11; req3 = 3'b001;
      @(posedge clk); #1;
      checks++;
      if (act3 !== {2'd0, 1'b0, 1'b0, 3'b001, 1'b0}) begin
         errors++; $display("FAIL inv_floor_latch: got %b expected %b", act3,
                            {2'd0, 1'b0, 1'b0, 3'b001, 1'b0});
      end
      req3 = 3'b000;
      @(posedge clk); #1;
      checks++;
      if (act3 !== {2'd0, 1'b0, 1'b0, 3'b001, 1'b0}) begin
         errors++; $display("FAIL inv_floor_hold: got %b expected %b", act3,
                            {2'd0, 1'b0, 1'b0, 3'b001, 1'b0});
      end
      floor3 = 2'd0;
      @(posedge clk); #1;
      checks++;
      if (act3 !== {2'd0, 1'b1, 1'b0, 3'b000, 1'b1}) begin
         errors++; $display("FAIL inv_floor_arrive: got %b expected %b", act3,
                            {2'd0, 1'b1, 1'b0, 3'b000, 1'b1});
      end
      rst3_n = 1'b0;
   endtask

   task automatic test_reset();
      drive(1'b0, 2'd0, 4'b0, 1'b0);
      drive(1'b0, 2'd0, 4'b0, 1'b0);
      checks++;
      if (act !== 9'b0) begin
         errors++; $display("FAIL reset: got %b expected %b", act, 9'b0);
      end
      checks++;
      if (act !== m_vec()) begin
         errors++; $display("FAIL reset_model: got %b expected %b", act, m_vec());
      end
   endtask

   task automatic test_serve_here();
      drive(1'b1, 2'd0, 4'b0001, 1'b0);
      checks++;
      if (act !== {2'd0, 1'b1, 1'b0, 4'b0000, 1'b1}) begin
         errors++; $display("FAIL serve_here: got %b expected %b", act,
                            {2'd0, 1'b1, 1'b0, 4'b0000, 1'b1});
      end
   endtask

   task automatic test_idle_pick();
      logic [8:0] exp_v [3];
      logic [1:0] fl_v  [3];
      logic [3:0] rq_v  [3];
      exp_v = '{{2'd1, 1'b1, 1'b1, 4'b1010, 1'b0},
                {2'd1, 1'b1, 1'b1, 4'b1000, 1'b1},
                {2'd3, 1'b1, 1'b1, 4'b1000, 1'b0}};
      fl_v  = '{2'd0, 2'd1, 2'd1};
      rq_v  = '{4'b1010, 4'b0000, 4'b0000};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, fl_v[i], rq_v[i], 1'b0);
         checks++;
         if (act !== exp_v[i]) begin
            errors++; $display("FAIL idle_pick[%0d]: got %b expected %b", i, act, exp_v[i]);
         end
      end
   endtask

   task automatic test_motion();
      logic [8:0] exp_v [6];
      logic [1:0] fl_v  [6];
      logic [3:0] rq_v  [6];
      logic       mv_v  [6];
      exp_v = '{{2'd3, 1'b1, 1'b1, 4'b1100, 1'b0},
                {2'd3, 1'b1, 1'b1, 4'b1100, 1'b0},
                {2'd2, 1'b1, 1'b1, 4'b1000, 1'b1},
                {2'd3, 1'b1, 1'b1, 4'b1000, 1'b0},
                {2'd3, 1'b1, 1'b1, 4'b0000, 1'b1},
                {2'd3, 1'b0, 1'b1, 4'b0000, 1'b0}};
      fl_v  = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
      rq_v  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      mv_v  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, fl_v[i], rq_v[i], mv_v[i]);
         checks++;
         if (act !== exp_v[i]) begin
            errors++; $display("FAIL motion[%0d]: got %b expected %b", i, act, exp_v[i]);
         end
      end
   endtask

   task automatic test_reversal();
      drive(1'b0, 2'd0, 4'b0, 1'b0);
      drive(1'b1, 2'd0, 4'b0100, 1'b0);
      checks++;
      if (act !== {2'd2, 1'b1, 1'b1, 4'b0100, 1'b0}) begin
         errors++; $display("FAIL reversal_start: got %b expected %b", act,
                            {2'd2, 1'b1, 1'b1, 4'b0100, 1'b0});
      end
      drive(1'b1, 2'd1, 4'b0001, 1'b1);
      drive(1'b1, 2'd2, 4'b0000, 1'b0);
      checks++;
      if (act !== {2'd2, 1'b1, 1'b1, 4'b0001, 1'b1}) begin
         errors++; $display("FAIL reversal_serve: got %b expected %b", act,
                            {2'd2, 1'b1, 1'b1, 4'b0001, 1'b1});
      end
      drive(1'b1, 2'd2, 4'b0000, 1'b0);
      checks++;
      if (act !== {2'd0, 1'b1, 1'b0, 4'b0001, 1'b0}) begin
         errors++; $display("FAIL reversal_down: got %b expected %b", act,
                            {2'd0, 1'b1, 1'b0, 4'b0001, 1'b0});
      end
   endtask

   task automatic test_midreset();
      drive(1'b0, 2'd0, 4'b0, 1'b0);
      drive(1'b1, 2'd0, 4'b1110, 1'b0);
      drive(1'b1, 2'd0, 4'b0001, 1'b1);
      checks++;
      if (act !== {2'd1, 1'b1, 1'b1, 4'b1111, 1'b0}) begin
         errors++; $display("FAIL midreset_pre: got %b expected %b", act,
                            {2'd1, 1'b1, 1'b1, 4'b1111, 1'b0});
      end
      drive(1'b0, 2'd0, 4'b0000, 1'b1);
      checks++;
      if (act !== 9'b0) begin
         errors++; $display("FAIL midreset: got %b expected %b", act, 9'b0);
      end
   endtask

   task automatic test_idle_park();
      logic [8:0] exp_v;
      drive(1'b0, 2'd0, 4'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 2'd0, 4'b0, 1'b0);
         exp_v = 9'b0;
`ifdef GOAL_SCHEDULER_PARK_EN
         if (i >= PC - 1) exp_v = {2'd2, 1'b1, 1'b1, 4'b0000, 1'b0};
`endif
         checks++;
         if (act !== exp_v) begin
            errors++; $display("FAIL idle_park[%0d]: got %b expected %b", i, act, exp_v);
         end
      end
`ifdef GOAL_SCHEDULER_PARK_EN
      drive(1'b1, 2'd1, 4'b0, 1'b1);
      drive(1'b1, 2'd2, 4'b0, 1'b0);
      checks++;
      if (act !== {2'd2, 1'b0, 1'b1, 4'b0000, 1'b0}) begin
         errors++; $display("FAIL park_arrive: got %b expected %b", act,
                            {2'd2, 1'b0, 1'b1, 4'b0000, 1'b0});
      end
`endif
      checks++;
      if (act !== m_vec()) begin
         errors++; $display("FAIL idle_park_model: got %b expected %b", act, m_vec());
      end
   endtask

   task automatic test_random();
      logic [1:0] fl;
      logic [3:0] rq;
      logic       mv;
      logic       rn;
      fl = 2'd0;
      for (int i = 0; i < 600; i++) begin
         rn = ($urandom_range(0, 59) != 0);
         mv = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) fl = 2'($urandom_range(0, 3));
         rq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         // Quiet stretches let the sweep drain and the idle path run.
         if ((i % 50) >= 38) begin
            rn = 1'b1;
            mv = 1'b0;
            rq = 4'b0;
         end
         drive(rn, fl, rq, mv);
         checks++;
         if (act !== m_vec()) begin
            errors++; $display("FAIL random[%0d]: got %b expected %b (gf,valid,dir,pending,served)",
                               i, act, m_vec());
         end
      end
   endtask

   initial begin
      test_invalid_floor();
      test_reset();
      test_serve_here();
      test_idle_pick();
      test_motion();
      test_reversal();
      test_midreset();
      test_idle_park();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
